// File: rtl/logic_gates_bist.sv
// BIST sequencer for the two-input gate block: sweeps all 28 gateType x {A,B} vectors and checks O.
// Optional LGB_STOP_ON_FAIL_EN: end the run at the first mismatch instead of sweeping all vectors.
module logic_gates_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    output logic [2:0]       gate_type,
    input  logic             gate_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_type,
    output logic             fail_a,
    output logic             fail_b
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       LAST_VEC    = 5'd27;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    logic [1:0]       state;
    logic [CNT_W-1:0] settleCnt;
    logic [4:0]       vecIdx;
    logic [4:0]       nextIdx;
    logic             goldenO;
    logic             mismatch;
    logic             lastCheck;

    function automatic logic golden(input logic [2:0] t, input logic a, input logic b);
        case (t)
            3'b000:  golden = a & b;
            3'b001:  golden = a | b;
            3'b010:  golden = ~a;
            3'b011:  golden = ~(a & b);
            3'b100:  golden = ~(a | b);
            3'b101:  golden = a ^ b;
            3'b110:  golden = ~(a ^ b);
            default: golden = 1'b0;
        endcase
    endfunction

    // The vector index maps straight onto {type, A, B} because the inner loop has exactly 4 entries.
    always_comb begin
        goldenO   = golden(gate_type, gate_a, gate_b);
        mismatch  = (gate_o != goldenO);
        nextIdx   = vecIdx + 5'd1;
`ifdef LGB_STOP_ON_FAIL_EN
        lastCheck = (vecIdx == LAST_VEC) || mismatch;
`else
        lastCheck = (vecIdx == LAST_VEC);
`endif
    end

    always_comb begin
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settleCnt  <= '0;
            vecIdx     <= '0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            gate_type  <= 3'b000;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_type  <= 3'b000;
            fail_a     <= 1'b0;
            fail_b     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SETTLE;
                        settleCnt  <= '0;
                        vecIdx     <= '0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        gate_type  <= 3'b000;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_type  <= 3'b000;
                        fail_a     <= 1'b0;
                        fail_b     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_type  <= gate_type;
                            fail_a     <= gate_a;
                            fail_b     <= gate_b;
                        end
                    end
                    if (lastCheck) begin
                        state     <= DONE;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        gate_type <= 3'b000;
                    end else begin
                        state     <= SETTLE;
                        settleCnt <= '0;
                        vecIdx    <= nextIdx;
                        gate_type <= nextIdx[4:2];
                        gate_a    <= nextIdx[1];
                        gate_b    <= nextIdx[0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
